// File: rtl/mem_arbiter.sv
// Two-master RAM arbiter (icache/dcache) with dcache burst lock and zero-latency pass-through.
// Optional icache anti-starvation hand-off is built when MEM_ARB_STARVE_EN is defined.
module mem_arbiter #(
   parameter int unsigned STARVE_LIMIT = 8,
   parameter int unsigned CNT_W        = 4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic        iwait,
   output logic [31:0] iload,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic        dwait,
   output logic [31:0] dload,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic [1:0]  ramstate
);

   typedef enum logic [1:0] {OwnIdle, OwnD, OwnI} own_e;

   localparam logic [1:0] RamAccess = 2'd2;

   if ((2 ** CNT_W) <= STARVE_LIMIT) begin : g_bad_cfg
      $error("CNT_W too narrow for STARVE_LIMIT");
   end

   own_e own_q, own_d;
   logic dreq, serve_d, serve_i, done;

   // The icache lock only holds while own is OwnI; otherwise dcache has priority.
   always_comb begin
      dreq    = dREN | dWEN;
      serve_d = 1'b0;
      serve_i = 1'b0;
      if (own_q == OwnI && iREN) begin
         serve_i = 1'b1;
      end else if (dreq) begin
         serve_d = 1'b1;
      end else if (iREN) begin
         serve_i = 1'b1;
      end
      done = (ramstate == RamAccess) && (serve_d || serve_i);
   end

`ifdef MEM_ARB_STARVE_EN
   localparam logic [CNT_W-1:0] Limit = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] scnt_q, scnt_d;
   logic             handoff;

   always_comb begin
      handoff = serve_d && done && (scnt_q == Limit);
      scnt_d  = '0;
      if (own_q == OwnD && iREN && !serve_i) begin
         scnt_d = (scnt_q == Limit) ? scnt_q : scnt_q + 1'b1;
      end
      if (handoff) begin
         scnt_d = '0;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         scnt_q <= '0;
      end else begin
         scnt_q <= scnt_d;
      end
   end
`else
   logic handoff;
   assign handoff = 1'b0;
`endif

   // Ownership only moves on a completed word; a stalled word keeps its owner.
   always_comb begin
      own_d = own_q;
      if (!serve_d && !serve_i) begin
         own_d = OwnIdle;
      end else if (done) begin
         if (serve_d) begin
            own_d = handoff ? OwnI : OwnD;
         end else begin
            own_d = dreq ? OwnIdle : OwnI;
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         own_q <= OwnIdle;
      end else begin
         own_q <= own_d;
      end
   end

   always_comb begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      iwait    = 1'b1;
      dwait    = 1'b1;
      iload    = '0;
      dload    = '0;
      if (!RST) begin
         if (serve_d) begin
            ramaddr  = daddr;
            ramstore = dstore;
            ramWEN   = dWEN;
            ramREN   = dREN & ~dWEN;
            if (done) begin
               dwait = 1'b0;
               dload = ramload;
            end
         end else if (serve_i) begin
            ramaddr = iaddr;
            ramREN  = 1'b1;
            if (done) begin
               iwait = 1'b0;
               iload = ramload;
            end
         end
      end
   end

endmodule
